// File: rtl/ex_md_stage_pkg.sv
// Shared encodings for the EX stage: opcode/func constants, aluOP and
// forward-select codes, the multiply/divide state enum and the ALU op decode.
package ex_md_stage_pkg;

   localparam logic [1:0] ALUOP_LDST = 2'b00, ALUOP_BR = 2'b01, ALUOP_R = 2'b10, ALUOP_I = 2'b11;
   localparam logic [1:0] FW_REG = 2'b00, FW_ZERO = 2'b01, FW_MEMWB = 2'b10, FW_EXMEM = 2'b11;

   localparam logic [5:0] OP_JAL   = 6'b000011, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001,
                          OP_SLTI  = 6'b001010, OP_SLTIU = 6'b001011, OP_ANDI = 6'b001100,
                          OP_ORI   = 6'b001101, OP_XORI = 6'b001110, OP_LUI   = 6'b001111;

   localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011,
                          F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111,
                          F_JALR = 6'b001001,
                          F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010, F_MTLO = 6'b010011,
                          F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011,
                          F_ADD  = 6'b100000, F_ADDU = 6'b100001, F_SUB  = 6'b100010, F_SUBU = 6'b100011,
                          F_AND  = 6'b100100, F_OR   = 6'b100101, F_XOR  = 6'b100110, F_NOR  = 6'b100111,
                          F_SLT  = 6'b101010, F_SLTU = 6'b101011;
   // Internal-only code for LUI; no R-type instruction uses this func value.
   localparam logic [5:0] F_LUI  = 6'b111111;

   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

   function automatic logic [5:0] alu_fn(input logic [1:0] aluop, input logic [5:0] opcode,
                                         input logic [5:0] func);
      logic [5:0] fn;
      fn = F_ADD;
      if (opcode == OP_JAL) fn = F_JALR;
      else begin
         case (aluop)
            ALUOP_LDST: fn = F_ADDU;
            ALUOP_BR:   fn = F_SUBU;
            ALUOP_R:    fn = func;
            default: begin
               case (opcode)
                  OP_SLTI:  fn = F_SLT;
                  OP_SLTIU: fn = F_SLTU;
                  OP_ANDI:  fn = F_AND;
                  OP_ORI:   fn = F_OR;
                  OP_XORI:  fn = F_XOR;
                  OP_LUI:   fn = F_LUI;
                  default:  fn = F_ADD;
               endcase
            end
         endcase
      end
      return fn;
   endfunction

endpackage

// File: rtl/ex_md_stage_md_unit.sv
// Iterative multiply/divide unit: one bit per cycle shift-add multiplier and
// restoring divider sharing one accumulator, plus the HI/LO registers.
module md_unit
   import ex_md_stage_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic               i_halt,
   input  logic               i_start,
   input  logic [1:0]         i_op,
   input  logic [NB_DATA-1:0] i_a,
   input  logic [NB_DATA-1:0] i_b,
   input  logic               i_mthi,
   input  logic               i_mtlo,
   output logic               o_stall,
   output logic [NB_DATA-1:0] o_hi,
   output logic [NB_DATA-1:0] o_lo
);
   localparam int NC = $clog2(NB_DATA + 1);

   md_state_e              state_q;
   logic [NC-1:0]          count_q;
   logic [NB_DATA-1:0]     opnd_q, hi_q, lo_q;
   logic [2*NB_DATA-1:0]   acc_q, acc_d, prod;
   logic                   is_div_q, neg_q, neg_rem_q, dz_q;
   logic                   a_neg, b_neg;
   logic [NB_DATA-1:0]     a_mag, b_mag, quo, rem;
   logic [NB_DATA:0]       sum, shifted, diff;

   // i_op[0] set means the unsigned variant; signed ops work on magnitudes.
   assign a_neg = ~i_op[0] & i_a[NB_DATA-1];
   assign b_neg = ~i_op[0] & i_b[NB_DATA-1];
   assign a_mag = a_neg ? -i_a : i_a;
   assign b_mag = b_neg ? -i_b : i_b;

   assign o_stall = (state_q == MD_IDLE && i_start && !i_halt) || state_q == MD_BUSY;
   assign o_hi = hi_q;
   assign o_lo = lo_q;

   // acc holds {upper product, multiplier} for MULT and {remainder, quotient} for DIV.
   always_comb begin
      sum     = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      shifted = acc_q[2*NB_DATA-1:NB_DATA-1];
      diff    = shifted - {1'b0, opnd_q};
      if (!is_div_q)     acc_d = {sum, acc_q[NB_DATA-1:1]};
      else if (diff[NB_DATA]) acc_d = {shifted[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b0};
      else               acc_d = {diff[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
      prod = neg_q ? -acc_d : acc_d;
      quo  = dz_q ? '1 : (neg_q ? -acc_d[NB_DATA-1:0] : acc_d[NB_DATA-1:0]);
      rem  = neg_rem_q ? -acc_d[2*NB_DATA-1:NB_DATA] : acc_d[2*NB_DATA-1:NB_DATA];
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q   <= MD_IDLE;
         count_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
      end else if (!i_halt) begin
         case (state_q)
            MD_IDLE: begin
               if (i_start) begin
                  state_q   <= MD_BUSY;
                  count_q   <= NC'(NB_DATA);
                  is_div_q  <= i_op[1];
                  neg_q     <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  dz_q      <= i_op[1] && (i_b == '0);
                  opnd_q    <= i_op[1] ? b_mag : a_mag;
                  acc_q     <= {{NB_DATA{1'b0}}, (i_op[1] ? a_mag : b_mag)};
               end else begin
                  if (i_mthi) hi_q <= i_a;
                  if (i_mtlo) lo_q <= i_a;
               end
            end
            MD_BUSY: begin
               acc_q   <= acc_d;
               count_q <= count_q - NC'(1);
               if (count_q == NC'(1)) begin
                  state_q <= MD_DONE;
                  hi_q    <= is_div_q ? rem : prod[2*NB_DATA-1:NB_DATA];
                  lo_q    <= is_div_q ? quo : prod[NB_DATA-1:0];
               end
            end
            default: state_q <= MD_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ex_md_stage.sv
// EX pipeline stage: operand forwarding, single-cycle ALU, iterative
// multiply/divide with HI/LO, and the EX/MEM pipeline register.
module ex_md_stage
   import ex_md_stage_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic               i_halt,
   input  logic               i_valid,
   input  logic [5:0]         i_opcode,
   input  logic [5:0]         i_func,
   input  logic [4:0]         i_shamt,
   input  logic [1:0]         i_aluOP,
   input  logic               i_immediate_flag,
   input  logic [NB_DATA-1:0] i_immediate,
   input  logic [NB_DATA-1:0] i_reg_DA,
   input  logic [NB_DATA-1:0] i_reg_DB,
   input  logic [1:0]         i_fw_a,
   input  logic [1:0]         i_fw_b,
   input  logic [NB_DATA-1:0] i_output_EXMEM,
   input  logic [NB_DATA-1:0] i_output_MEMWB,
   input  logic [NB_REG-1:0]  i_rt,
   input  logic [NB_REG-1:0]  i_rd,
   input  logic               i_regDst,
   input  logic               i_regWrite,
   input  logic               i_memWrite,
   input  logic               i_mem2reg,
   output logic               o_stall,
   output logic [NB_DATA-1:0] o_result,
   output logic [NB_DATA-1:0] o_data4Mem,
   output logic [NB_REG-1:0]  o_write_reg,
   output logic               o_regWrite,
   output logic               o_memWrite,
   output logic               o_mem2reg
);
   logic               is_r, is_link, md_start, stall;
   logic [5:0]         fn;
   logic [NB_DATA-1:0] fw_a, fw_b, op_a, op_b, alu_res, hi, lo;
   logic [NB_DATA-1:0] result_q, data4mem_q;
   logic [NB_REG-1:0]  write_reg_q;
   logic               regwrite_q, memwrite_q, mem2reg_q;

   assign is_r     = (i_aluOP == ALUOP_R);
   assign is_link  = (i_opcode == OP_JAL) || (is_r && i_func == F_JALR);
   assign md_start = i_valid && is_r && (i_func[5:2] == 4'b0110);
   assign fn       = alu_fn(i_aluOP, i_opcode, i_func);

   // Links carry the return address on DA, so forwarding must not replace it.
   always_comb begin
      case (i_fw_a)
         FW_MEMWB: fw_a = i_output_MEMWB;
         FW_EXMEM: fw_a = i_output_EXMEM;
         FW_ZERO:  fw_a = '0;
         default:  fw_a = i_reg_DA;
      endcase
      case (i_fw_b)
         FW_MEMWB: fw_b = i_output_MEMWB;
         FW_EXMEM: fw_b = i_output_EXMEM;
         FW_ZERO:  fw_b = '0;
         default:  fw_b = i_reg_DB;
      endcase
      if (is_link) begin
         fw_a = i_reg_DA;
         fw_b = i_reg_DB;
      end
      op_a = fw_a;
      op_b = i_immediate_flag ? i_immediate : fw_b;
   end

   always_comb begin
      alu_res = '0;
      case (fn)
         F_ADD, F_ADDU: alu_res = op_a + op_b;
         F_SUB, F_SUBU: alu_res = op_a - op_b;
         F_AND:  alu_res = op_a & op_b;
         F_OR:   alu_res = op_a | op_b;
         F_XOR:  alu_res = op_a ^ op_b;
         F_NOR:  alu_res = ~(op_a | op_b);
         F_SLT:  alu_res = NB_DATA'($signed(op_a) < $signed(op_b));
         F_SLTU: alu_res = NB_DATA'(op_a < op_b);
         F_SLL:  alu_res = op_b << i_shamt;
         F_SRL:  alu_res = op_b >> i_shamt;
         F_SRA:  alu_res = $signed(op_b) >>> i_shamt;
         F_SLLV: alu_res = op_b << op_a[4:0];
         F_SRLV: alu_res = op_b >> op_a[4:0];
         F_SRAV: alu_res = $signed(op_b) >>> op_a[4:0];
         F_LUI:  alu_res = op_b << (NB_DATA / 2);
         F_JALR: alu_res = op_a;
         F_MFHI: alu_res = hi;
         F_MFLO: alu_res = lo;
         default: alu_res = '0;
      endcase
   end

   md_unit #(.NB_DATA(NB_DATA)) u_md (
      .clk     (clk),
      .i_reset (i_reset),
      .i_halt  (i_halt),
      .i_start (md_start),
      .i_op    (i_func[1:0]),
      .i_a     (op_a),
      .i_b     (op_b),
      .i_mthi  (i_valid && is_r && i_func == F_MTHI),
      .i_mtlo  (i_valid && is_r && i_func == F_MTLO),
      .o_stall (stall),
      .o_hi    (hi),
      .o_lo    (lo)
   );

   always_ff @(posedge clk) begin
      if (i_reset || (!i_halt && stall)) begin
         result_q    <= '0;
         data4mem_q  <= '0;
         write_reg_q <= '0;
         regwrite_q  <= 1'b0;
         memwrite_q  <= 1'b0;
         mem2reg_q   <= 1'b0;
      end else if (!i_halt) begin
         result_q    <= alu_res;
         data4mem_q  <= fw_b;
         write_reg_q <= i_regDst ? i_rd : i_rt;
         regwrite_q  <= i_regWrite;
         memwrite_q  <= i_memWrite;
         mem2reg_q   <= i_mem2reg;
      end
   end

   assign o_stall     = stall;
   assign o_result    = result_q;
   assign o_data4Mem  = data4mem_q;
   assign o_write_reg = write_reg_q;
   assign o_regWrite  = regwrite_q;
   assign o_memWrite  = memwrite_q;
   assign o_mem2reg   = mem2reg_q;

endmodule

// File: doc/ex_md_stage.md
EX_MD_STAGE -- requirements
Module: ex_md_stage

Interface
REQ-001 The block SHALL have a single clock, clk; reset is i_reset, synchronous and active-high.
REQ-002 Parameter NB_DATA, default 32: datapath width, even and at least 8.
REQ-003 Parameter NB_REG, default 5: register-index width.
REQ-004 Ports SHALL be:
 clk  in  1  clock
 i_reset  in  1  sync active-high reset
 i_halt  in  1  freeze all state
 i_valid  in  1  instruction present in EX
 i_opcode / i_func  in  6 each  instruction fields
 i_shamt  in  5  shift amount
 i_aluOP  in  2  00 ld/st, 01 branch, 10 R-type, 11 I-type
 i_immediate_flag  in  1  B operand = immediate
 i_immediate, i_reg_DA, i_reg_DB  in  NB_DATA each  operands
 i_fw_a / i_fw_b  in  2 each  00 reg, 10 MEMWB, 11 EXMEM, 01 zero
 i_output_EXMEM, i_output_MEMWB  in  NB_DATA each  forwarded values
 i_rt, i_rd  in  NB_REG each  destinations
 i_regDst, i_regWrite, i_memWrite, i_mem2reg  in  1 each  control
 o_stall  out  1  hold IF/ID/EX, combinational
 o_result, o_data4Mem  out  NB_DATA each  EX/MEM data
 o_write_reg  out  NB_REG  EX/MEM destination
 o_regWrite, o_memWrite, o_mem2reg  out  1 each  EX/MEM control

Function
REQ-005 Forwarding SHALL select A and B per i_fw_a/i_fw_b; JAL (opcode 000011) and JALR (R-type, func 001001) SHALL bypass forwarding; data4Mem SHALL be forwarded B before immediate substitution.
REQ-006 Single-cycle ops SHALL use the existing ALU with the existing aluOP-to-op mapping.
REQ-007 MD ops (R-type) SHALL be decoded as: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
REQ-008 MD FSM states SHALL be IDLE, BUSY, DONE.
REQ-009 IDLE to BUSY SHALL occur on i_valid and MULT/MULTU/DIV/DIVU and !i_halt; on this transition the block latches operands and sets count = NB_DATA.
REQ-010 o_stall SHALL be 1 in the start cycle and in every BUSY cycle.
REQ-011 BUSY SHALL process one bit per cycle.
REQ-012 On count==1, BUSY SHALL go to DONE and write HI/LO at that edge.
REQ-013 DONE SHALL drive o_stall=0, ignore any start, and go to IDLE next.
REQ-014 Total stall SHALL be NB_DATA+1 cycles.
REQ-015 MULT/MULTU SHALL produce {HI,LO} = full 2*NB_DATA-bit signed/unsigned product.
REQ-016 DIV/DIVU SHALL produce LO=quotient and HI=remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-017 Divide by zero SHALL give LO=all-ones and HI=dividend, with full latency.
REQ-018 Signed MIN/-1 SHALL give LO=MIN and HI=0.
REQ-019 MFHI/MFLO SHALL drive HI/LO onto the result; MTHI/MTLO SHALL write forwarded A into HI/LO at the edge, when not halted and not stalled.
REQ-020 EX/MEM capture SHALL apply: o_write_reg = i_regDst ? i_rd : i_rt.
REQ-021 While o_stall=1, EX/MEM SHALL capture a bubble: all control 0, data 0.
REQ-022 While i_halt=1, the FSM, count, HI/LO and EX/MEM SHALL hold; o_stall SHALL keep its held-state value.

Reset
REQ-023 Reset SHALL set the FSM to IDLE, count=0, HI=LO=0 and all EX/MEM outputs to 0.
REQ-024 Reset during BUSY SHALL abort the op with no HI/LO update; o_stall SHALL be 0 in the cycle after reset.
REQ-025 Reset SHALL override i_halt.

Structure
REQ-026 A shared package SHALL hold the opcode/func constants, aluOP and forward-select encodings, and the MD state enum.
REQ-027 The sub-module md_unit SHALL contain the FSM, the shift-add multiplier, the restoring divider and HI/LO.
REQ-028 The existing ALU and EXMEM SHALL be reused unchanged.

Verification
REQ-029 MULT A=-3, B=7 -> o_stall high for 33 cycles; then MFHI=0xFFFFFFFF and MFLO=0xFFFFFFEB.
REQ-030 DIV A=-7, B=2 -> LO=0xFFFFFFFD and HI=0xFFFFFFFF; DIVU A=7, B=0 -> LO=0xFFFFFFFF and HI=7.
REQ-031 MULT immediately followed by MFLO -> MFLO returns the new LO; EX/MEM shows 33 bubbles with o_regWrite=0.
REQ-032 i_reset asserted on the 10th BUSY cycle -> next cycle o_stall=0, HI=LO=0, state IDLE.
REQ-033 i_halt held 5 cycles mid-BUSY -> stall extends to 38 cycles; result unchanged.
REQ-034 ADD with i_fw_a=11 and i_output_EXMEM=5, B=3 -> o_result=8 one cycle later; JALR with i_fw_a=11 -> uses i_reg_DA.
